// File: rtl/frame_sequencer_pkg.sv
// Shared audio definitions for the frame sequencer: step type, default divider,
// step constants and the step-to-strobe decode.
package frame_sequencer_pkg;

  typedef logic [2:0] frame_step_t;

  localparam int FS_DIV_DEFAULT = 32768;

  localparam frame_step_t STEP_SWEEP_A = 3'd2;
  localparam frame_step_t STEP_SWEEP_B = 3'd6;
  localparam frame_step_t STEP_ENV     = 3'd7;

  typedef struct packed {
    logic length;
    logic sweep;
    logic envelope;
  } frame_strobes_t;

  // Even steps clock the length counters; sweep rides on two of them.
  function automatic frame_strobes_t decodeStep(input frame_step_t step);
    frame_strobes_t strobes;
    strobes.length   = ~step[0];
    strobes.sweep    = (step == STEP_SWEEP_A) || (step == STEP_SWEEP_B);
    strobes.envelope = (step == STEP_ENV);
    return strobes;
  endfunction

endpackage

// File: rtl/frame_sequencer_prescaler.sv
// Free-running 0..DIV-1 prescaler; wrap pulses on the last count while enabled.
// Dropping enable clears the count so power-on always starts from zero.
module frame_prescaler #(
  parameter int DIV = 32768
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_divCnt;
  logic          w_atLast;

  assign w_atLast = (r_divCnt == LAST);
  assign wrap     = enable && w_atLast;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_divCnt <= '0;
    end else if (!enable) begin
      r_divCnt <= '0;
    end else if (w_atLast) begin
      r_divCnt <= '0;
    end else begin
      r_divCnt <= r_divCnt + ONE;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// APU frame sequencer: divides the system clock into an 8-step frame and emits
// length, sweep and envelope strobes, plus the NR52 readback register.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int DIV = FS_DIV_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  NR52,
  input  logic [3:0]  ch_active,
  output logic        length_tick,
  output logic        sweep_tick,
  output logic        envelope_tick,
  output logic [2:0]  frame_step,
  output logic [7:0]  nr52_status
);

  logic           w_enable;
  logic           w_wrap;
  logic           w_unusedNr52Bits;
  frame_strobes_t w_decoded;

  frame_step_t    r_step;
  frame_strobes_t r_strobes;
  logic [7:0]     r_status;

  assign w_enable         = NR52[7];
  assign w_unusedNr52Bits = ^NR52[6:0];
  assign w_decoded        = decodeStep(r_step);

  frame_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(w_enable),
    .wrap  (w_wrap)
  );

  // Strobes decode the step before it advances, so they and frame_step move together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_step    <= '0;
      r_strobes <= '0;
      r_status  <= 8'h00;
    end else begin
      r_status <= {w_enable, 3'b000, ch_active & {4{w_enable}}};
      if (!w_enable) begin
        r_step    <= '0;
        r_strobes <= '0;
      end else if (w_wrap) begin
        r_step    <= frame_step_t'(r_step + 3'd1);
        r_strobes <= w_decoded;
      end else begin
        r_strobes <= '0;
      end
    end
  end

  assign length_tick   = r_strobes.length;
  assign sweep_tick    = r_strobes.sweep;
  assign envelope_tick = r_strobes.envelope;
  assign frame_step    = r_step;
  assign nr52_status   = r_status;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer at DIV=4: a count-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_frame_sequencer;

  localparam int DIV = 4;

  logic       clock;
  logic       reset;
  logic [7:0] NR52;
  logic [3:0] ch_active;
  logic       length_tick;
  logic       sweep_tick;
  logic       envelope_tick;
  logic [2:0] frame_step;
  logic [7:0] nr52_status;

  int checks = 0;
  int errors = 0;

  frame_sequencer #(
    .DIV(DIV)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .NR52         (NR52),
    .ch_active    (ch_active),
    .length_tick  (length_tick),
    .sweep_tick   (sweep_tick),
    .envelope_tick(envelope_tick),
    .frame_step   (frame_step),
    .nr52_status  (nr52_status)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Reference model: counts enabled edges since power-on/reset and derives
  // everything from that count with plain arithmetic.
  int         mCount = 0;
  logic       mLen   = 1'b0;
  logic       mSweep = 1'b0;
  logic       mEnv   = 1'b0;
  logic [2:0] mStep  = 3'd0;
  logic [7:0] mStat  = 8'h00;

  function automatic bit isBoundary(input int n);
    return (n > 0) && (n % DIV == 0);
  endfunction

  function automatic int stepBefore(input int n);
    return ((n / DIV) - 1) % 8;
  endfunction

  always @(posedge clock) begin
    if (reset || !NR52[7]) begin
      mCount <= 0;
      mLen   <= 1'b0;
      mSweep <= 1'b0;
      mEnv   <= 1'b0;
      mStep  <= 3'd0;
      mStat  <= 8'h00;
    end else begin
      mCount <= mCount + 1;
      mLen   <= isBoundary(mCount + 1) && (stepBefore(mCount + 1) % 2 == 0);
      mSweep <= isBoundary(mCount + 1) &&
                (stepBefore(mCount + 1) == 2 || stepBefore(mCount + 1) == 6);
      mEnv   <= isBoundary(mCount + 1) && (stepBefore(mCount + 1) == 7);
      mStep  <= 3'(((mCount + 1) / DIV) % 8);
      mStat  <= {1'b1, 3'b000, ch_active};
    end
  end

  always @(negedge clock) begin
    checkOutput("model_length", int'(length_tick), int'(mLen));
    checkOutput("model_sweep", int'(sweep_tick), int'(mSweep));
    checkOutput("model_envelope", int'(envelope_tick), int'(mEnv));
    checkOutput("model_step", int'(frame_step), int'(mStep));
    checkOutput("model_status", int'(nr52_status), int'(mStat));
  end

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  logic [32:0] lenMask;
  logic [32:0] sweepMask;
  logic [32:0] envMask;
  logic [32:0] lenExp;
  logic [32:0] sweepExp;
  logic [32:0] envExp;
  int          lenCount;
  int          sweepCount;
  int          envCount;
  int          stepAt31;
  int          stepAt32;
  int          edgesToLength;

  initial begin
    reset     = 1'b1;
    NR52      = 8'h80;
    ch_active = 4'b0000;
    applyStimulus(3);
    checkOutput("reset_step", int'(frame_step), 0);
    checkOutput("reset_status", int'(nr52_status), 0);
    checkOutput("reset_strobes", int'({length_tick, sweep_tick, envelope_tick}), 0);

    // Reset release with power on: strobe timing over the first 32 cycles.
    lenMask    = '0;
    sweepMask  = '0;
    envMask    = '0;
    lenCount   = 0;
    sweepCount = 0;
    envCount   = 0;
    reset      = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1);
      if (k <= 32) begin
        lenMask[k]   = length_tick;
        sweepMask[k] = sweep_tick;
        envMask[k]   = envelope_tick;
      end
      if (k == 31) stepAt31 = int'(frame_step);
      if (k == 32) stepAt32 = int'(frame_step);
      lenCount   += int'(length_tick);
      sweepCount += int'(sweep_tick);
      envCount   += int'(envelope_tick);
    end
    lenExp   = (33'd1 << 4) | (33'd1 << 12) | (33'd1 << 20) | (33'd1 << 28);
    sweepExp = (33'd1 << 12) | (33'd1 << 28);
    envExp   = (33'd1 << 32);
    checkOutput("length_cycles", (lenMask == lenExp) ? 1 : 0, 1);
    checkOutput("sweep_cycles", (sweepMask == sweepExp) ? 1 : 0, 1);
    checkOutput("envelope_cycles", (envMask == envExp) ? 1 : 0, 1);
    checkOutput("length_count_64", lenCount, 8);
    checkOutput("sweep_count_64", sweepCount, 4);
    checkOutput("envelope_count_64", envCount, 2);
    checkOutput("step_before_wrap", stepAt31, 7);
    checkOutput("step_after_wrap", stepAt32, 0);

    // Power off on the last count of step 7: the envelope strobe must not appear.
    applyStimulus(31);
    checkOutput("pre_off_step", int'(frame_step), 7);
    NR52 = 8'h00;
    applyStimulus(1);
    checkOutput("off_envelope", int'(envelope_tick), 0);
    checkOutput("off_step", int'(frame_step), 0);
    checkOutput("off_strobes", int'({length_tick, sweep_tick, envelope_tick}), 0);

    // Power on after idle: first length strobe exactly DIV edges later.
    applyStimulus(10);
    NR52          = 8'h80;
    edgesToLength = -1;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1);
      if (edgesToLength < 0 && length_tick) begin
        edgesToLength = k;
        checkOutput("poweron_step", int'(frame_step), 1);
      end else if (edgesToLength < 0) begin
        checkOutput("poweron_step_hold", int'(frame_step), 0);
      end
    end
    checkOutput("poweron_latency", edgesToLength, 4);

    // Status readback with channel flags gated by power.
    ch_active = 4'b1010;
    applyStimulus(1);
    checkOutput("status_on", int'(nr52_status), 8'h8A);
    NR52 = 8'h00;
    applyStimulus(1);
    checkOutput("status_off", int'(nr52_status), 8'h00);

    // Reset landing on a step-2 wrap edge wins over the strobes.
    reset = 1'b1;
    applyStimulus(1);
    reset = 1'b0;
    NR52  = 8'h80;
    applyStimulus(11);
    checkOutput("pre_reset_step", int'(frame_step), 2);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("reset_wrap_strobes", int'({length_tick, sweep_tick, envelope_tick}), 0);
    checkOutput("reset_wrap_step", int'(frame_step), 0);
    checkOutput("reset_wrap_status", int'(nr52_status), 0);
    reset = 1'b0;
    applyStimulus(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
